// File: rtl/accel_pkg.sv
// Shared constants and helpers for the accelerometer decimal/binary converters.
// The display converter imports the same package so both sides agree on format.
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PACK    = 2'd2
  } state_e;

  localparam int COUNT_W          = 10;
  localparam int MG_PER_LSB_SHIFT = 2;
  localparam int POS_MAX          = 511;
  localparam int NEG_MAX_MAG      = 512;

  localparam int ACCEL_W       = 16;
  localparam int AD_LOW_MSB    = 15;  // holds count[2:0]
  localparam int AD_LOW_LSB    = 13;
  localparam int AD_HIGH_MSB   = 6;   // holds count[9:3]
  localparam int AD_HIGH_LSB   = 0;

  function automatic logic [ACCEL_W-1:0] pack_accel(input logic [COUNT_W-1:0] count);
    logic [ACCEL_W-1:0] word;
    word = {ACCEL_W{1'b0}};
    word[AD_LOW_MSB:AD_LOW_LSB]   = count[2:0];
    word[AD_HIGH_MSB:AD_HIGH_LSB] = count[COUNT_W-1:3];
    return word;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction step: a BCD digit of 8 or more loses 3.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Correct the digit after the right shift carried a half-ten into it
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd8) begin
      digit_o = digit_i - 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/decimal_to_accel_data.sv
// Converts a signed 4-digit BCD mg value into a 10-bit sensor count (4 mg/LSB)
// via reverse double-dabble, then clamps and packs it into the Accel_Data layout.
module decimal_to_accel_data
  import accel_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int ITER  = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 negative,
  input  logic [3:0]           thousands,
  input  logic [3:0]           hundreds,
  input  logic [3:0]           tens,
  input  logic [3:0]           ones,
  output logic [ACCEL_W-1:0]   Accel_Data,
  output logic [COUNT_W-1:0]   Decimal_Data,
  output logic                 busy,
  output logic                 done,
  output logic                 saturated,
  output logic                 digit_err
);

  localparam int BCD_W = 16;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(ITER);
  localparam int MAG_W = BIN_W - MG_PER_LSB_SHIFT;

  state_e               state_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [BIN_W-1:0]     bin_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic [ACCEL_W-1:0]   accel_q;
  logic [COUNT_W-1:0]   dec_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sat_q;
  logic                 derr_q;

  logic [SR_W-1:0]      shifted_s;
  logic [BCD_W-1:0]     bcd_d;
  logic [BIN_W-1:0]     bin_d;
  logic [MAG_W-1:0]     mag_s;
  logic [MAG_W-1:0]     clamped_s;
  logic [COUNT_W-1:0]   count_d;
  logic                 sat_d;
  logic                 digit_bad_s;

  assign shifted_s = {bcd_q, bin_q} >> 1;
  assign bin_d     = shifted_s[BIN_W-1:0];

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (shifted_s[BIN_W + 4*g +: 4]),
      .digit_o (bcd_d[4*g +: 4])
    );
  end

  assign digit_bad_s = (thousands > 4'd9) | (hundreds > 4'd9) |
                       (tens > 4'd9) | (ones > 4'd9);

  // Drop the two sub-LSB mg bits, then clamp to the asymmetric 10-bit range
  always_comb begin
    mag_s     = bin_q[BIN_W-1:MG_PER_LSB_SHIFT];
    clamped_s = mag_s;
    count_d   = {COUNT_W{1'b0}};
    sat_d     = 1'b0;
    if (!neg_q) begin
      if (mag_s > MAG_W'(POS_MAX)) begin
        count_d = COUNT_W'(POS_MAX);
        sat_d   = 1'b1;
      end else begin
        count_d = COUNT_W'(mag_s);
        sat_d   = 1'b0;
      end
    end else begin
      if (mag_s > MAG_W'(NEG_MAX_MAG)) begin
        clamped_s = MAG_W'(NEG_MAX_MAG);
        sat_d     = 1'b1;
      end else begin
        clamped_s = mag_s;
        sat_d     = 1'b0;
      end
      count_d = COUNT_W'(MAG_W'(0) - clamped_s);
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcd_q   <= {BCD_W{1'b0}};
      bin_q   <= {BIN_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      neg_q   <= 1'b0;
      accel_q <= {ACCEL_W{1'b0}};
      dec_q   <= {COUNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      derr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (digit_bad_s) begin
              done_q <= 1'b1;
              derr_q <= 1'b1;
            end else begin
              bcd_q   <= {thousands, hundreds, tens, ones};
              bin_q   <= {BIN_W{1'b0}};
              neg_q   <= negative;
              cnt_q   <= CNT_W'(ITER - 1);
              busy_q  <= 1'b1;
              state_q <= ST_CONVERT;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(0)) begin
            state_q <= ST_PACK;
          end else begin
            state_q <= ST_CONVERT;
          end
        end
        ST_PACK: begin
          dec_q   <= count_d;
          accel_q <= pack_accel(count_d);
          sat_q   <= sat_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Accel_Data   = accel_q;
  assign Decimal_Data = dec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign saturated    = sat_q;
  assign digit_err    = derr_q;

endmodule

// File: tb/tb_decimal_to_accel_data.sv
// Self-checking bench: directed and random decimal inputs against an arithmetic model.
module tb_decimal_to_accel_data;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        negative;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic [15:0] Accel_Data;
  logic [9:0]  Decimal_Data;
  logic        busy, done, saturated, digit_err;

  int checks   = 0;
  int failures = 0;

  int exp_dec  = 0;
  int exp_acc  = 0;
  int exp_sat  = 0;
  int exp_derr = 0;

  always #5 clk = ~clk;

  decimal_to_accel_data dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .negative     (negative),
    .thousands    (thousands),
    .hundreds     (hundreds),
    .tens         (tens),
    .ones         (ones),
    .Accel_Data   (Accel_Data),
    .Decimal_Data (Decimal_Data),
    .busy         (busy),
    .done         (done),
    .saturated    (saturated),
    .digit_err    (digit_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: value/4 truncated, clamped to [-512, 511], then register split
  task automatic model(input bit neg, input int d3, input int d2, input int d1, input int d0);
    int v;
    int m;
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) begin
      exp_sat  = 0;
      exp_derr = 1;
    end else begin
      v = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
      m = v / 4;
      exp_sat  = 0;
      exp_derr = 0;
      if (!neg) begin
        if (m > 511) begin m = 511; exp_sat = 1; end
        exp_dec = m;
      end else begin
        if (m > 512) begin m = 512; exp_sat = 1; end
        exp_dec = (1024 - m) % 1024;
      end
      exp_acc = ((exp_dec % 8) * 8192) + (exp_dec / 8);
    end
  endtask

  task automatic drive(input bit neg, input int d3, input int d2, input int d1, input int d0);
    negative  = neg;
    thousands = d3[3:0];
    hundreds  = d2[3:0];
    tens      = d1[3:0];
    ones      = d0[3:0];
  endtask

  // Called at a negedge; issues start, waits for done, checks everything
  task automatic run(input string tag, input bit neg, input int d3, input int d2,
                     input int d1, input int d0, input bit b2b);
    int n;
    drive(neg, d3, d2, d1, d0);
    start = 1'b1;
    model(neg, d3, d2, d1, d0);
    @(negedge clk);
    start = 1'b0;
    if (exp_derr == 0) chk({tag, " busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, (exp_derr != 0) ? 0 : 15);
    chk({tag, " Decimal_Data"}, int'(Decimal_Data), exp_dec);
    chk({tag, " Accel_Data"}, int'(Accel_Data), exp_acc);
    chk({tag, " saturated"}, int'(saturated), exp_sat);
    chk({tag, " digit_err"}, int'(digit_err), exp_derr);
    if (!b2b) begin
      @(negedge clk);
      chk({tag, " done pulse"}, int'(done), 0);
      chk({tag, " busy idle"}, int'(busy), 0);
    end
  endtask

  initial begin
    int n;
    int dones;
    int mg;
    int mag;
    rst_n = 1'b0;
    start = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    #12;
    chk("reset Accel_Data", int'(Accel_Data), 0);
    chk("reset Decimal_Data", int'(Decimal_Data), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset saturated", int'(saturated), 0);
    chk("reset digit_err", int'(digit_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("p0100", 1'b0, 0, 1, 0, 0, 1'b0);
    run("n0100", 1'b1, 0, 1, 0, 0, 1'b0);
    run("n0007", 1'b1, 0, 0, 0, 7, 1'b0);
    run("p2044", 1'b0, 2, 0, 4, 4, 1'b0);
    run("p9999", 1'b0, 9, 9, 9, 9, 1'b0);
    run("n2048", 1'b1, 2, 0, 4, 8, 1'b0);
    run("n9999", 1'b1, 9, 9, 9, 9, 1'b0);
    run("p0100b", 1'b0, 0, 1, 0, 0, 1'b0);
    run("tensA", 1'b0, 0, 1, 10, 0, 1'b0);
    run("n0000", 1'b1, 0, 0, 0, 0, 1'b0);
    run("p0003", 1'b0, 0, 0, 0, 3, 1'b0);
    run("p2048", 1'b0, 2, 0, 4, 8, 1'b0);
    run("n2052", 1'b1, 2, 0, 5, 2, 1'b0);

    // Starts while busy are dropped, not queued
    run("b2b_a", 1'b0, 1, 2, 3, 4, 1'b1);
    run("b2b_b", 1'b1, 0, 8, 7, 6, 1'b0);
    drive(1'b0, 0, 4, 0, 0);
    model(1'b0, 0, 4, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(1'b1, 9, 9, 9, 9);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      start = (n == 5 || n == 10) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk("ignore latency", n, 15);
    chk("ignore Decimal_Data", int'(Decimal_Data), exp_dec);
    chk("ignore Accel_Data", int'(Accel_Data), exp_acc);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ignore extra done", dones, 0);

    // Reset in the middle of a conversion
    drive(1'b0, 0, 5, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset Accel_Data", int'(Accel_Data), 0);
    chk("midreset Decimal_Data", int'(Decimal_Data), 0);
    chk("midreset busy", int'(busy), 0);
    exp_dec = 0;
    exp_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midreset no done", dones, 0);
    run("after_reset", 1'b0, 0, 5, 0, 0, 1'b0);

    // Random values, roughly one in eight with a bad digit
    for (int i = 0; i < 40; i++) begin
      int d3, d2, d1, d0;
      d3 = $urandom_range(0, 9);
      d2 = $urandom_range(0, 9);
      d1 = $urandom_range(0, 9);
      d0 = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      run("random", 1'($urandom_range(0, 1)), d3, d2, d1, d0, 1'($urandom_range(0, 1)));
    end

    // Loopback of every count through the display-side decimal form
    for (int c = -512; c < 512; c++) begin
      mg  = c * 4;
      mag = (mg < 0) ? -mg : mg;
      run("loopback", (c < 0), mag / 1000, (mag / 100) % 10, (mag / 10) % 10, mag % 10, 1'b1);
      chk("loopback count", int'(Decimal_Data), (c + 1024) % 1024);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decimal_to_accel_data.md
Name: decimal_to_accel_data

Overview:
Sequential inverse of the accelerometer binary-to-decimal path. Takes a signed 4-digit BCD acceleration in mg (sign flag plus thousands/hundreds/tens/ones) and converts it to the sensor's 10-bit two's-complement count (1 LSB = 4 mg). It then packs the result into the 16-bit two-register Accel_Data format used by the display path.
Used to build threshold/offset register writes from user-entered decimal values, and for loopback checking of the display converter.

Parameters:
BIN_W, 14, width of the intermediate binary magnitude (9999 < 2^14)
ITER, 14, reverse double-dabble shift iterations (must equal BIN_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
negative  input  1  sign of the decimal value (1 = negative)
thousands  input  4  BCD digit
hundreds  input  4  BCD digit
tens  input  4  BCD digit
ones  input  4  BCD digit
Accel_Data  output  16  packed result: [15:13] = count[2:0], [6:0] = count[9:3], all other bits 0
Decimal_Data  output  10  two's-complement count
busy  output  1  high while converting
done  output  1  one-cycle completion pulse
saturated  output  1  valid with done: magnitude was clamped
digit_err  output  1  valid with done: an input digit was > 9

Behaviour:
Reset values:
- Accel_Data = 0, Decimal_Data = 0, busy = 0, done = 0, saturated = 0, digit_err = 0.
- FSM returns to IDLE.
- Reset asserted mid-conversion aborts it. No done is issued.

FSM states: IDLE, CONVERT, PACK.

IDLE:
- On start at edge E0 with all digits <= 9:
  - load shift register {bcd[15:0] = {thousands, hundreds, tens, ones}, bin[13:0] = 0};
  - latch negative;
  - counter = ITER-1;
  - busy <= 1;
  - go to CONVERT.
- On start with any digit > 9:
  - at E0, done <= 1, digit_err <= 1, saturated <= 0;
  - Accel_Data and Decimal_Data hold their previous values;
  - stay in IDLE.
- done, saturated and digit_err are cleared on the next edge.

CONVERT (one iteration per clock, edges E1..E14):
- Shift {bcd, bin} right by 1.
- Then, in each 4-bit digit of bcd, if the digit is >= 8, subtract 3.
- Decrement the counter. When the counter = 0, go to PACK.

PACK (edge E15):
- mag12 = bin[13:2] (truncates the mg value toward zero).
- Positive: if mag12 > 511, count = 511 and saturated = 1; else count = mag12.
- Negative: if mag12 > 512, mag12 is clamped to 512 and saturated = 1. count = -mag12 in 10-bit two's complement.
- Negative zero gives count 0, not a negative code.
- Register Decimal_Data and Accel_Data.
- done <= 1, busy <= 0, go to IDLE.

Timing and handshake:
- Latency: done is high in the cycle following E15, i.e. 15 clocks after start is sampled.
- busy is high from E0 to E15.
- start while busy is ignored; it is not queued.
- A start in the same cycle that done is high is accepted (back-to-back). Its done follows 15 clocks later.
- Outputs hold their values until the next successful PACK.

Decomposition:
Shared package (accel_pkg) holds:
- state enum;
- constants COUNT_W = 10, MG_PER_LSB_SHIFT = 2, POS_MAX = 511, NEG_MAX_MAG = 512;
- the Accel_Data field bit positions.
These constants are shared with the display converter so the two formats cannot diverge.

One natural sub-module, bcd_digit_adjust: combinational "if >= 8 then -3" on 4 bits, instantiated four times. The FSM, counter, scale/clamp and packing stay in the top level.

Test Plan:
- +0100 mg, start -> done after 15 clocks; Decimal_Data = 0x019, Accel_Data = 0x2003, saturated = 0.
- -0100 mg -> Decimal_Data = 0x3E7, Accel_Data = 0xE07C. -0007 mg -> count -1 = 0x3FF, Accel_Data = 0xE07F (truncation toward zero).
- +2044 -> 0xE03F, saturated = 0. +9999 -> 0xE03F, saturated = 1. -2048 -> 0x0040, saturated = 0. -9999 -> 0x0040, saturated = 1.
- -0000 -> Accel_Data = 0x0000. A tens digit of 0xA -> done in the next cycle with digit_err = 1 and Accel_Data unchanged.
- start pulsed again at cycles 5 and 10 of a conversion -> ignored, exactly one done. A start coincident with done -> second result 15 clocks later.
- rst_n dropped at cycle 7 of a conversion -> all outputs 0 immediately, no done. A fresh start after release converts correctly.
- Loopback: every count from -512 to 511 -> display converter -> this block returns the identical count (sampled exhaustively).
